// File: rtl/dct_pkg.sv
// Shared types for the 2D DCT datapath: sample format and 8-wide row/column vectors.
// Pure declarations; no logic, no latency, no flow control.
package dct_pkg;
    localparam int DATA_W = 16;
    localparam int N      = 8;
    localparam int FRAC_W = 4;
    localparam int IDX_W  = $clog2(N);

    typedef logic signed [DATA_W-1:0] sample_t;
    typedef sample_t [N-1:0]          vec_t;
endpackage

// File: rtl/transpose_bank.sv
// One 8x8 sample store: row write on the clock edge, combinational column read.
// Write takes effect next cycle; read has no latency; no flow control of its own.
module transpose_bank
    import dct_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we_i,
    input  logic [IDX_W-1:0] wr_row_i,
    input  vec_t             wr_dat_i,
    input  logic [IDX_W-1:0] rd_col_i,
    output vec_t             rd_dat_o
);
    vec_t mem_q [N];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < N; r++) begin
                mem_q[r] <= '0;
            end
        end else if (we_i) begin
            mem_q[wr_row_i] <= wr_dat_i;
        end
    end

    always_comb begin
        rd_dat_o = '0;
        for (int r = 0; r < N; r++) begin
            rd_dat_o[r] = mem_q[r][rd_col_i];
        end
    end
endmodule

// File: rtl/dct_transpose_buffer.sv
// Ping-pong 8x8 transpose between row and column DCT passes: rows in, columns out.
// Column 0 valid the cycle after the 8th row; row_ready drops only when both banks are full.
module dct_transpose_buffer
    import dct_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear_i,
    input  logic                row_valid_i,
    output logic                row_ready_o,
    input  logic [DATA_W-1:0]   y0_i,
    input  logic [DATA_W-1:0]   y1_i,
    input  logic [DATA_W-1:0]   y2_i,
    input  logic [DATA_W-1:0]   y3_i,
    input  logic [DATA_W-1:0]   y4_i,
    input  logic [DATA_W-1:0]   y5_i,
    input  logic [DATA_W-1:0]   y6_i,
    input  logic [DATA_W-1:0]   y7_i,
    output logic                col_valid_o,
    input  logic                col_ready_i,
    output logic [DATA_W-1:0]   x0_o,
    output logic [DATA_W-1:0]   x1_o,
    output logic [DATA_W-1:0]   x2_o,
    output logic [DATA_W-1:0]   x3_o,
    output logic [DATA_W-1:0]   x4_o,
    output logic [DATA_W-1:0]   x5_o,
    output logic [DATA_W-1:0]   x6_o,
    output logic [DATA_W-1:0]   x7_o,
    output logic [IDX_W-1:0]    col_idx_o,
    output logic                col_last_o
);
    logic [1:0]       full_q, full_d;
    logic             wr_bank_q, wr_bank_d;
    logic             rd_bank_q, rd_bank_d;
    logic [IDX_W-1:0] wr_row_q, wr_row_d;
    logic [IDX_W-1:0] rd_col_q, rd_col_d;
    logic             row_acc, col_acc;
    vec_t             row_dat;
    vec_t             col_dat;
    vec_t             bank_rd [2];

    assign row_dat = {y7_i, y6_i, y5_i, y4_i, y3_i, y2_i, y1_i, y0_i};

    assign row_ready_o = !full_q[wr_bank_q];
    assign col_valid_o = full_q[rd_bank_q];
    assign row_acc     = row_valid_i && row_ready_o && !clear_i;
    assign col_acc     = col_ready_i && col_valid_o && !clear_i;

    for (genvar b = 0; b < 2; b++) begin : g_bank
        transpose_bank u_bank (
            .clk      (clk),
            .rst_n    (rst_n),
            .we_i     (row_acc && (wr_bank_q == 1'(b))),
            .wr_row_i (wr_row_q),
            .wr_dat_i (row_dat),
            .rd_col_i (rd_col_q),
            .rd_dat_o (bank_rd[b])
        );
    end

    // A bank completing fill and the other completing drain on one edge touch
    // different full bits, so both updates apply independently.
    always_comb begin
        full_d    = full_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        wr_row_d  = wr_row_q;
        rd_col_d  = rd_col_q;
        if (clear_i) begin
            full_d    = '0;
            wr_bank_d = 1'b0;
            rd_bank_d = 1'b0;
            wr_row_d  = '0;
            rd_col_d  = '0;
        end else begin
            if (row_acc) begin
                wr_row_d = wr_row_q + 3'd1;
                if (wr_row_q == 3'(N - 1)) begin
                    full_d[wr_bank_q] = 1'b1;
                    wr_bank_d         = !wr_bank_q;
                end
            end
            if (col_acc) begin
                rd_col_d = rd_col_q + 3'd1;
                if (rd_col_q == 3'(N - 1)) begin
                    full_d[rd_bank_q] = 1'b0;
                    rd_bank_d         = !rd_bank_q;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q    <= '0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            wr_row_q  <= '0;
            rd_col_q  <= '0;
        end else begin
            full_q    <= full_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            wr_row_q  <= wr_row_d;
            rd_col_q  <= rd_col_d;
        end
    end

    assign col_dat    = rd_bank_q ? bank_rd[1] : bank_rd[0];
    assign col_idx_o  = rd_col_q;
    assign col_last_o = col_valid_o && (rd_col_q == 3'(N - 1));

    assign x0_o = col_dat[0];
    assign x1_o = col_dat[1];
    assign x2_o = col_dat[2];
    assign x3_o = col_dat[3];
    assign x4_o = col_dat[4];
    assign x5_o = col_dat[5];
    assign x6_o = col_dat[6];
    assign x7_o = col_dat[7];
endmodule

// File: tb/tb_dct_transpose_buffer.sv
// Directed bench for dct_transpose_buffer: block-queue reference model checked every
// cycle, plus literal expectations for reset, latency, backpressure and flush cases.
module tb_dct_transpose_buffer;
    typedef logic [63:0][15:0] blk_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic        row_valid = 1'b0;
    logic        row_ready;
    logic        col_valid;
    logic        col_ready = 1'b0;
    logic [15:0] y [8];
    logic [15:0] x [8];
    logic [2:0]  col_idx;
    logic        col_last;

    int checks = 0;
    int failures = 0;
    int col_cnt = 0;
    int stalls = 0;

    blk_t fullq [$];
    blk_t cur;
    int   m_row = 0;
    int   m_col = 0;
    bit   racc, cacc;

    always #5 clk = ~clk;

    dct_transpose_buffer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear_i     (clear),
        .row_valid_i (row_valid),
        .row_ready_o (row_ready),
        .y0_i        (y[0]),
        .y1_i        (y[1]),
        .y2_i        (y[2]),
        .y3_i        (y[3]),
        .y4_i        (y[4]),
        .y5_i        (y[5]),
        .y6_i        (y[6]),
        .y7_i        (y[7]),
        .col_valid_o (col_valid),
        .col_ready_i (col_ready),
        .x0_o        (x[0]),
        .x1_o        (x[1]),
        .x2_o        (x[2]),
        .x3_o        (x[3]),
        .x4_o        (x[4]),
        .x5_o        (x[5]),
        .x6_o        (x[6]),
        .x7_o        (x[7]),
        .col_idx_o   (col_idx),
        .col_last_o  (col_last)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] pat(input int b, input int r, input int c);
        if (b == 0 && r == 3 && c == 5) return 16'hFFF0;
        return 16'((b << 12) | (r << 8) | c);
    endfunction

    // Reference: completed blocks wait in a FIFO; at most two can be held.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || clear) begin
            fullq.delete();
            m_row = 0;
            m_col = 0;
        end else begin
            racc = row_valid && (fullq.size() < 2);
            cacc = col_ready && (fullq.size() > 0);
            if (cacc) begin
                if (m_col == 7) begin
                    fullq.delete(0);
                    m_col = 0;
                end else begin
                    m_col++;
                end
            end
            if (racc) begin
                for (int c = 0; c < 8; c++) cur[m_row*8 + c] = y[c];
                if (m_row == 7) begin
                    fullq.push_back(cur);
                    m_row = 0;
                end else begin
                    m_row++;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("row_ready", {31'b0, row_ready}, {31'b0, fullq.size() < 2});
            chk("col_valid", {31'b0, col_valid}, {31'b0, fullq.size() > 0});
            if (fullq.size() > 0) begin
                chk("col_idx", {29'b0, col_idx}, 32'(m_col));
                chk("col_last", {31'b0, col_last}, {31'b0, m_col == 7});
                for (int r = 0; r < 8; r++) chk("x_data", {16'b0, x[r]}, {16'b0, fullq[0][r*8 + m_col]});
                if (col_ready) col_cnt++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_row(input int b, input int r);
        int  n;
        bit  acc;
        row_valid = 1'b1;
        for (int c = 0; c < 8; c++) y[c] = pat(b, r, c);
        n = 0;
        acc = 1'b0;
        while (!acc && n < 100) begin
            @(negedge clk);
            acc = row_ready;
            tick();
            n++;
        end
        if (!acc) chk("push_timeout", 32'd0, 32'd1);
        stalls += n - 1;
    endtask

    task automatic push_block(input int b);
        for (int r = 0; r < 8; r++) push_row(b, r);
        row_valid = 1'b0;
    endtask

    task automatic drain(input int n);
        col_ready = 1'b1;
        repeat (n) tick();
        col_ready = 1'b0;
    endtask

    int accepted;

    initial begin
        for (int c = 0; c < 8; c++) y[c] = '0;
        repeat (3) tick();
        rst_n = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst_row_ready", {31'b0, row_ready}, 32'd1);
        chk("rst_col_valid", {31'b0, col_valid}, 32'd0);
        chk("rst_col_idx", {29'b0, col_idx}, 32'd0);
        chk("rst_col_last", {31'b0, col_last}, 32'd0);
        for (int r = 0; r < 8; r++) chk("rst_x", {16'b0, x[r]}, 32'd0);
        for (int i = 0; i < 10; i++) begin
            tick();
            @(negedge clk);
            chk("idle_col_valid", {31'b0, col_valid}, 32'd0);
        end
        tick();

        // Single block: latency, transposition, -1.0 sample, col_last
        for (int r = 0; r < 7; r++) push_row(0, r);
        chk("pre8_col_valid", {31'b0, col_valid}, 32'd0);
        push_row(0, 7);
        row_valid = 1'b0;
        chk("lat_col_valid", {31'b0, col_valid}, 32'd1);
        col_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk("sb_col_idx", {29'b0, col_idx}, 32'(c));
            chk("sb_col_last", {31'b0, col_last}, {31'b0, c == 7});
            chk("sb_x3", {16'b0, x[3]}, (c == 5) ? 32'h0000FFF0 : 32'(16'h0300 | c));
            chk("sb_x7", {16'b0, x[7]}, 32'(16'h0700 | c));
            tick();
        end
        col_ready = 1'b0;
        @(negedge clk);
        chk("sb_done_col_valid", {31'b0, col_valid}, 32'd0);
        tick();

        // Streaming 4 blocks
        col_ready = 1'b1;
        stalls = 0;
        for (int b = 1; b <= 4; b++)
            for (int r = 0; r < 8; r++) push_row(b, r);
        row_valid = 1'b0;
        chk("stream_stalls", 32'(stalls), 32'd0);
        drain(20);
        chk("stream_col_cnt", 32'(col_cnt), 32'd40);

        // Backpressure: 20 rows offered, 16 accepted
        accepted = 0;
        row_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            for (int c = 0; c < 8; c++) y[c] = pat(5 + accepted / 8, accepted % 8, c);
            @(negedge clk);
            if (row_ready) accepted++;
            tick();
        end
        for (int c = 0; c < 8; c++) y[c] = pat(7, 0, c);
        chk("bp_accepted", 32'(accepted), 32'd16);
        @(negedge clk);
        chk("bp_row_ready", {31'b0, row_ready}, 32'd0);
        chk("bp_col_idx", {29'b0, col_idx}, 32'd0);
        chk("bp_x0", {16'b0, x[0]}, 32'h5000);
        chk("bp_x7", {16'b0, x[7]}, 32'h5700);
        tick();
        col_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("bp_drain_row_ready", {31'b0, row_ready}, 32'd0);
            tick();
        end
        col_ready = 1'b0;
        @(negedge clk);
        chk("bp_release_row_ready", {31'b0, row_ready}, 32'd1);
        chk("bp_next_x0", {16'b0, x[0]}, 32'h6000);
        tick();
        col_ready = 1'b1;
        for (int r = 1; r < 8; r++) push_row(7, r);
        row_valid = 1'b0;
        drain(30);
        chk("bp_col_cnt", 32'(col_cnt), 32'd64);

        // Row 8 of bank 1 and column 7 of bank 0 on the same edge
        push_block(8);
        col_ready = 1'b1;
        push_block(9);
        col_ready = 1'b0;
        @(negedge clk);
        chk("sim_full", {30'b0, dut.full_q}, 32'd2);
        chk("sim_col_valid", {31'b0, col_valid}, 32'd1);
        chk("sim_row_ready", {31'b0, row_ready}, 32'd1);
        chk("sim_col_idx", {29'b0, col_idx}, 32'd0);
        chk("sim_x0", {16'b0, x[0]}, 32'h9000);
        tick();
        drain(12);
        chk("sim_col_cnt", 32'(col_cnt), 32'd80);

        // Mid-block reset
        for (int r = 0; r < 5; r++) push_row(10, r);
        row_valid = 1'b0;
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("rst_mid_col_valid", {31'b0, col_valid}, 32'd0);
            tick();
        end
        push_block(11);
        @(negedge clk);
        chk("rst_new_col_valid", {31'b0, col_valid}, 32'd1);
        chk("rst_new_x1", {16'b0, x[1]}, 32'hB100);
        tick();
        drain(12);
        @(negedge clk);
        chk("rst_one_block", {31'b0, col_valid}, 32'd0);
        chk("rst_col_cnt", 32'(col_cnt), 32'd88);
        tick();

        // Mid-block clear
        for (int r = 0; r < 5; r++) push_row(12, r);
        row_valid = 1'b0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("clr_mid_col_valid", {31'b0, col_valid}, 32'd0);
            tick();
        end
        push_block(13);
        @(negedge clk);
        chk("clr_new_x0", {16'b0, x[0]}, 32'hD000);
        chk("clr_new_x4", {16'b0, x[4]}, 32'hD400);
        tick();
        drain(12);
        @(negedge clk);
        chk("clr_one_block", {31'b0, col_valid}, 32'd0);
        chk("clr_col_cnt", 32'(col_cnt), 32'd96);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
